// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
// Holds default sizes, the FSM state type and the id-width helper.

package arb_pkg;

    localparam int N_DEF  = 7;
    localparam int WW_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports: req_i (request bits), ptr_i (highest-priority index);
//        pick_o (one-hot winner), idx_o (winner index), vld_o (any winner).

module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = id_w(N_DEF)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin : pick_p
        int j;
        pick_o = '0;
        idx_o  = '0;
        vld_o  = 1'b0;
        j      = 0;
        // Scan from ptr upward, wrapping from N-1 back to 0.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!vld_o && req_i[j]) begin
                vld_o     = 1'b1;
                pick_o[j] = 1'b1;
                idx_o     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter with per-requester burst quotas.
// Ports: clk, rst (sync, active-high), arb_en, req[N], weight[N*WW], ack;
//        grant (one-hot), grant_vld, grant_id (owner index).

module wrr_arb
    import arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int WW = WW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arb_en,
    input  logic [N-1:0]         req,
    input  logic [N*WW-1:0]      weight,
    input  logic                 ack,
    output logic [N-1:0]         grant,
    output logic                 grant_vld,
    output logic [id_w(N)-1:0]   grant_id
);

    localparam int IW = id_w(N);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          vld_q,   vld_d;
    logic [WW-1:0] quota_q, quota_d;
    logic [WW-1:0] cnt_q,   cnt_d;

    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [WW-1:0] win_w;
    logic          last_beat;
    logic          release_c;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    assign win_w = weight[int'(pick_idx)*WW +: WW];

    // Widened so cnt+1 cannot wrap before the compare.
    assign last_beat =
        (({1'b0, cnt_q} + 1'b1) == {1'b0, quota_q});

    // Owner dropping its request ends the tenure regardless of ack.
    assign release_c = !req[owner_q] || (ack && last_beat);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        vld_d   = vld_q;
        quota_d = quota_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_en && pick_vld) begin
                    state_d = OWN;
                    grant_d = pick_oh;
                    vld_d   = 1'b1;
                    owner_d = pick_idx;
                    quota_d = (win_w == '0) ? WW'(1) : win_w;
                end
            end
            OWN: begin
                if (release_c) begin
                    state_d = IDLE;
                    grant_d = '0;
                    vld_d   = 1'b0;
                    owner_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (owner_q == IW'(N - 1))
                            ? '0 : owner_q + 1'b1;
                end else if (ack) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                vld_d   = 1'b0;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            vld_q   <= 1'b0;
            quota_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            quota_q <= quota_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_vld = vld_q;
    assign grant_id  = owner_q;

endmodule

// File: tb/tb_wrr_arb.sv
// Directed testbench for wrr_arb (N=7, WW=3).
// Drives linear stimulus and checks grant outputs after each edge.

module tb_wrr_arb;

    logic        clk;
    logic        rst;
    logic        arb_en;
    logic [6:0]  req;
    logic [20:0] weight;
    logic        ack;
    logic [6:0]  grant;
    logic        grant_vld;
    logic [2:0]  grant_id;

    int checks = 0;
    int errors = 0;

    wrr_arb #(
        .N  (7),
        .WW (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en),
        .req       (req),
        .weight    (weight),
        .ack       (ack),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setw(input int i, input int v);
        logic [2:0] w;
        w = 3'(v);
        weight[i*3 +: 3] = w;
    endtask

    // own < 0 means no owner expected.
    task automatic chk(input string tag, input int own);
        logic [6:0] eg;
        logic       ev;
        logic [2:0] ei;
        eg = '0;
        ev = 1'b0;
        ei = '0;
        if (own >= 0) begin
            eg[own] = 1'b1;
            ev      = 1'b1;
            ei      = 3'(own);
        end
        checks++;
        assert ({grant, grant_vld, grant_id} === {eg, ev, ei})
        else begin
            errors++;
            $error("FAIL %s got grant=%b vld=%b id=%0d exp grant=%b vld=%b id=%0d",
                   tag, grant, grant_vld, grant_id, eg, ev, ei);
        end
    endtask

    initial begin
        rst    = 1'b1;
        arb_en = 1'b0;
        req    = '0;
        weight = '0;
        ack    = 1'b0;

        // Reset and zero-weight round robin: 1,3,6,1
        tick(); chk("reset", -1);
        rst = 1'b0; arb_en = 1'b1; ack = 1'b1;
        req = 7'b100_1010;
        tick(); chk("rr_g1", 1);
        tick(); chk("rr_b1", -1);
        tick(); chk("rr_g3", 3);
        tick(); chk("rr_b3", -1);
        tick(); chk("rr_g6", 6);
        tick(); chk("rr_b6", -1);
        tick(); chk("rr_g1b", 1);
        tick(); chk("rr_b1b", -1);

        // Weighted bursts: 0 x3, idle, 1 x1, idle, 0
        rst = 1'b1; tick(); chk("rst2", -1);
        rst = 1'b0;
        req = 7'b000_0011;
        weight = '0; setw(0, 3); setw(1, 1);
        tick(); chk("w0_a", 0);
        tick(); chk("w0_b", 0);
        tick(); chk("w0_c", 0);
        tick(); chk("w0_rel", -1);
        tick(); chk("w1_a", 1);
        tick(); chk("w1_rel", -1);
        tick(); chk("w0_again", 0);

        // Owner 2, quota 4, drops req after 2 acks; weight change ignored
        rst = 1'b1; tick(); chk("rst3", -1);
        rst = 1'b0;
        weight = '0; setw(2, 4);
        req = 7'b000_0100;
        tick(); chk("o2_a", 2);
        setw(2, 1);
        tick(); chk("o2_quota_kept", 2);
        tick(); chk("o2_c", 2);
        req = 7'b001_1010;
        tick(); chk("o2_drop", -1);
        tick(); chk("ptr3", 3);
        req = '0;
        tick(); chk("o3_rel", -1);

        // arb_en low blocks; ptr now 4
        arb_en = 1'b0; req = 7'b111_1111;
        weight = '0; setw(4, 3);
        tick(); chk("blk_a", -1);
        tick(); chk("blk_b", -1);
        tick(); chk("blk_c", -1);
        arb_en = 1'b1;
        tick(); chk("en_g4", 4);
        arb_en = 1'b0;
        tick(); chk("dis_own_b", 4);
        tick(); chk("dis_own_c", 4);
        tick(); chk("dis_rel", -1);
        tick(); chk("dis_idle", -1);

        // Wrap-around from ptr 6 (ptr now 5)
        weight = '0; arb_en = 1'b1;
        req = 7'b010_0000;
        tick(); chk("g5", 5);
        req = 7'b100_0001;
        tick(); chk("g5_rel", -1);
        tick(); chk("wrap_g6", 6);
        tick(); chk("g6_rel", -1);
        tick(); chk("wrap_g0", 0);
        tick(); chk("g0_rel", -1);

        // Reset mid-tenure (owner 3), then ptr=0 priority
        req = 7'b000_1000; ack = 1'b0;
        tick(); chk("o3_own", 3);
        tick(); chk("o3_hold", 3);
        rst = 1'b1; req = 7'b111_1111; ack = 1'b1;
        tick(); chk("rst_mid", -1);
        rst = 1'b0;
        tick(); chk("post_rst_g0", 0);

        // Sole requester wins again after the bubble
        req = 7'b000_0001;
        tick(); chk("solo_rel", -1);
        tick(); chk("solo_again", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrr_arb.md
WRR_ARB -- requirements
Module: wrr_arb

Interface
REQ-001 SHALL have parameter N, default 7, meaning the number of requesters.
REQ-002 SHALL have parameter WW, default 3, meaning the per-requester weight width in bits.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the synchronous, active-high reset.
REQ-005 SHALL have port arb_en  input  1  meaning new grants are allowed while high.
REQ-006 SHALL have port req  input  N  meaning the per-requester request level, bit i for requester i.
REQ-007 SHALL have port weight  input  N*WW  meaning the burst quota of requester i in bits [i*WW +: WW].
REQ-008 SHALL have port ack  input  1  meaning the current owner completed one beat this cycle.
REQ-009 SHALL have port grant  output  N  meaning the one-hot grant, or all zeros.
REQ-010 SHALL have port grant_vld  output  1  meaning grant is non-zero.
REQ-011 SHALL have port grant_id  output  $clog2(N)  meaning the index of the owner; 0 when grant_vld=0.

Function
REQ-012 SHALL use a two-state FSM: IDLE and OWN.
REQ-013 In IDLE with arb_en=1 and req!=0, SHALL pick the winner as the first set req bit at or above ptr, wrapping from N-1 to 0, and enter OWN.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled at edge k produces grant after edge k (visible during cycle k+1).
REQ-015 On entering OWN, SHALL latch quota = weight of the winner; quota 0 SHALL be treated as 1.
REQ-016 In OWN, SHALL increment beat count on each cycle with ack=1; ack in IDLE SHALL be ignored.
REQ-017 SHALL release the grant when ack=1 and beat count+1 == quota, or when req[owner]=0; release has priority if both occur.
REQ-018 On release, SHALL set ptr = owner+1 mod N and return to IDLE; grant SHALL be 0 for at least one cycle between owners.
REQ-019 The same requester SHALL be eligible again after release; with only that requester active it SHALL win again after the bubble cycle.
REQ-020 arb_en=0 SHALL block new grants in IDLE only; an existing OWN tenure SHALL complete normally.
REQ-021 Changes to weight during OWN SHALL NOT affect the latched quota.
REQ-022 grant, grant_vld and grant_id SHALL be registered outputs, mutually consistent every cycle.

Reset
REQ-023 On rst=1 at a rising edge: state=IDLE, ptr=0, beat count=0, grant=0, grant_vld=0, grant_id=0.
REQ-024 Reset mid-tenure SHALL drop the grant on the following cycle with no completion; rst SHALL override all other inputs.

Structure
REQ-025 SHALL place the default N and WW, the FSM state enum (IDLE, OWN) and the ID width function in package arb_pkg.
REQ-026 SHALL instantiate one sub-module rr_pick: combinational rotating-priority picker (inputs req, ptr; outputs one-hot pick and index).
REQ-027 SHALL NOT use latches; beat counter width is WW bits.

Verification
REQ-028 Reset, then req=7'b100_1010 with all weights 0, arb_en=1 and ack=1 every OWN cycle -> grant order 1,3,6,1 with one idle cycle between each grant.
REQ-029 req=7'b000_0011, weight0=3, weight1=1, ack held high -> grant 0 for 3 cycles, idle, grant 1 for 1 cycle, idle, grant 0 again.
REQ-030 Owner 2 with quota 4; req[2] drops after 2 acks -> grant drops the next cycle and ptr=3.
REQ-031 arb_en=0 with req=7'b111_1111 -> grant stays 0; when arb_en rises, requester ptr is granted after one cycle.
REQ-032 ptr=6, req=7'b100_0001 -> 6 wins first; after release, 0 wins (wrap-around).
REQ-033 Assert rst during OWN (grant=7'b000_1000) -> grant=0 on the next cycle, and the first grant after reset follows ptr=0 priority.
